// File: rtl/inverse_matrix.sv
// inverse_matrix: sequential 2x2 signed Q16.16 matrix inverter with one shared 48-cycle restoring divider.
// Optional macro INVERSE_MATRIX_ROUND_EN selects round-half-away-from-zero quotients instead of truncation.

module inverse_matrix #(
  parameter logic [31:0] M00 = 32'h0004_0000,
  parameter logic [31:0] M01 = 32'h0007_0000,
  parameter logic [31:0] M10 = 32'h0002_0000,
  parameter logic [31:0] M11 = 32'h0006_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] ram1,
  output logic [31:0] write
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DET, S_SING, S_DIV, S_WR, S_DONE
  } state_t;

  state_t state, next_state;

  logic [31:0] in_ram [4];
  logic [31:0] res_ram [4];
  logic [1:0]  rd_idx, el_idx, last_idx, next_el;
  logic        show_sing;

  logic signed [31:0] a, b, c, d, det, det_c;
  logic signed [63:0] prod_ad, prod_bc;
  logic signed [31:0] load_num, load_det;

  logic [47:0] quo, mag_q;
  logic [31:0] rem, dvs, result;
  logic [32:0] shifted;
  logic        sub_ok, neg;
  logic [5:0]  cnt;
`ifdef INVERSE_MATRIX_ROUND_EN
  logic        round_up;
`endif

  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic signed [31:0] numerator(input logic [1:0] k,
                                                   input logic signed [31:0] aa, bb, cc, dd);
    case (k)
      2'd0:    return dd;
      2'd1:    return -bb;
      2'd2:    return -cc;
      default: return aa;
    endcase
  endfunction

  assign prod_ad = 64'(a) * 64'(d);
  assign prod_bc = 64'(b) * 64'(c);
  assign det_c   = 32'((prod_ad - prod_bc) >>> 16);
  assign next_el = el_idx + 2'd1;

  // The divider is reloaded both from DET (element 0, fresh determinant) and from WR (next element).
  always_comb begin
    load_num = numerator(next_el, a, b, c, d);
    load_det = det;
    if (state == S_DET) begin
      load_num = numerator(2'd0, a, b, c, d);
      load_det = det_c;
    end
  end

  assign shifted = {rem, quo[47]};
  assign sub_ok  = shifted >= {1'b0, dvs};

  // Magnitude gets rounded (optionally), then signed and clamped to the 32-bit range.
  always_comb begin
`ifdef INVERSE_MATRIX_ROUND_EN
    round_up = {rem, 1'b0} >= {1'b0, dvs};
    mag_q    = quo + {47'd0, round_up};
`else
    mag_q    = quo;
`endif
    if (neg)
      result = (mag_q > 48'h0000_8000_0000) ? 32'h8000_0000 : (~mag_q[31:0] + 32'd1);
    else
      result = (mag_q > 48'h0000_7FFF_FFFF) ? 32'h7FFF_FFFF : mag_q[31:0];
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_READ;
      S_READ: if (rd_idx == 2'd3) next_state = S_DET;
      S_DET:  next_state = (det_c == 32'sd0) ? S_SING : S_DIV;
      S_DIV:  if (cnt == 6'd47) next_state = S_WR;
      S_WR:   next_state = (el_idx == 2'd3) ? S_DONE : S_DIV;
      S_SING: next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ram1      <= '0;
      rd_idx    <= '0;
      el_idx    <= '0;
      last_idx  <= '0;
      show_sing <= 1'b0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      det       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      in_ram[0] <= M00;
      in_ram[1] <= M01;
      in_ram[2] <= M10;
      in_ram[3] <= M11;
      for (int i = 0; i < 4; i++) res_ram[i] <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_idx <= '0;
            el_idx <= '0;
          end
        end
        S_READ: begin
          ram1 <= in_ram[rd_idx];
          case (rd_idx)
            2'd0:    a <= in_ram[0];
            2'd1:    b <= in_ram[1];
            2'd2:    c <= in_ram[2];
            default: d <= in_ram[3];
          endcase
          rd_idx <= rd_idx + 2'd1;
        end
        S_DET: begin
          det    <= det_c;
          el_idx <= '0;
          quo    <= {mag32(load_num), 16'd0};
          rem    <= '0;
          dvs    <= mag32(load_det);
          neg    <= load_num[31] ^ load_det[31];
          cnt    <= '0;
        end
        S_DIV: begin
          quo <= {quo[46:0], sub_ok};
          rem <= sub_ok ? 32'(shifted - {1'b0, dvs}) : shifted[31:0];
          cnt <= cnt + 6'd1;
        end
        S_WR: begin
          res_ram[el_idx] <= result;
          last_idx        <= el_idx;
          show_sing       <= 1'b0;
          el_idx          <= next_el;
          quo             <= {mag32(load_num), 16'd0};
          rem             <= '0;
          dvs             <= mag32(load_det);
          neg             <= load_num[31] ^ load_det[31];
          cnt             <= '0;
        end
        S_SING: show_sing <= 1'b1;
        default: ;
      endcase
    end
  end

  // The write port reflects the last stored result word, or the singular marker.
  assign write = show_sing ? 32'h8000_0000 : res_ram[last_idx];

endmodule

// File: tb/tb_inverse_matrix.sv
// tb_inverse_matrix: drives five parameterised inverters with randomised timing and checks them against
// an arithmetic reference model (mirrors INVERSE_MATRIX_ROUND_EN when it is defined).

module tb_inverse_matrix;

  localparam int NU = 5;
  // units: 0 default, 1 singular, 2 identity, 3 mixed signs, 4 saturating
  localparam logic [31:0] P00 [NU] = '{32'h0004_0000, 32'h0002_0000, 32'h0001_0000, 32'hFFFC_C000, 32'h0001_0000};
  localparam logic [31:0] P01 [NU] = '{32'h0007_0000, 32'h0004_0000, 32'h0000_0000, 32'h0001_8000, 32'h0000_0000};
  localparam logic [31:0] P10 [NU] = '{32'h0002_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_C000, 32'h0000_0000};
  localparam logic [31:0] P11 [NU] = '{32'h0006_0000, 32'h0002_0000, 32'h0001_0000, 32'h0002_2000, 32'hFFFF_FFFF};

  logic        clk = 1'b0;
  logic        rst_v   [NU];
  logic        start_v [NU];
  logic [31:0] ram1_v  [NU];
  logic [31:0] write_v [NU];
  logic [31:0] exp_write [NU];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : gen_dut
    inverse_matrix #(
      .M00(P00[g]), .M01(P01[g]), .M10(P10[g]), .M11(P11[g])
    ) u_dut (
      .clk(clk), .rst(rst_v[g]), .start(start_v[g]), .ram1(ram1_v[g]), .write(write_v[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0][31:0] getMatrix(input int u);
    logic [3:0][31:0] m;
    m[0] = P00[u];
    m[1] = P01[u];
    m[2] = P10[u];
    m[3] = P11[u];
    return m;
  endfunction

  // Inverse from plain 64-bit arithmetic: det, numerator * 2^16 / det, rounding, clamp.
  function automatic void refModel(input logic [3:0][31:0] m, output logic [3:0][31:0] q, output bit sing);
    longint av, bv, cv, dv, dd, n, qq, r;
    int     det;
    int     nums [4];
    av = longint'(int'(m[0]));
    bv = longint'(int'(m[1]));
    cv = longint'(int'(m[2]));
    dv = longint'(int'(m[3]));
    det = int'((av * dv - bv * cv) >>> 16);
    sing = (det == 0);
    nums[0] = int'(m[3]);
    nums[1] = -int'(m[1]);
    nums[2] = -int'(m[2]);
    nums[3] = int'(m[0]);
    q = '0;
    if (!sing) begin
      dd = longint'(det);
      for (int k = 0; k < 4; k++) begin
        n  = longint'(nums[k]) * 64'sd65536;
        qq = n / dd;
        r  = n % dd;
`ifdef INVERSE_MATRIX_ROUND_EN
        if (2 * (r < 0 ? -r : r) >= (dd < 0 ? -dd : dd))
          qq = qq + (((n < 0) != (dd < 0)) ? -64'sd1 : 64'sd1);
`endif
        if (qq > 64'sd2147483647)       q[k] = 32'h7FFF_FFFF;
        else if (qq < -64'sd2147483648) q[k] = 32'h8000_0000;
        else                            q[k] = 32'(qq);
      end
    end
  endfunction

  task automatic resetUnit(input int u);
    rst_v[u] = 1'b1;
    tick();
    rst_v[u] = 1'b0;
    exp_write[u] = '0;
  endtask

  // Runs one inversion on unit u; with hold=1 start stays high to test the restart from IDLE.
  task automatic applyStimulus(input int u, input int width, input bit hold);
    logic [3:0][31:0] m, q;
    bit sing;
    int last, wr;
    m = getMatrix(u);
    refModel(m, q, sing);
    last = sing ? 7 : 202;
    start_v[u] = 1'b1;
    tick();
    if (!hold && width == 1) start_v[u] = 1'b0;
    for (int e = 1; e <= last; e++) begin
      tick();
      if (!hold && e == width - 1) start_v[u] = 1'b0;
      if (e >= 1 && e <= 4)
        checkOutput($sformatf("u%0d_ram1_e%0d", u, e), ram1_v[u], m[e-1]);
      if (sing) begin
        if (e == 5) checkOutput($sformatf("u%0d_write_pre_sing", u), write_v[u], exp_write[u]);
        if (e == 6) begin
          exp_write[u] = 32'h8000_0000;
          checkOutput($sformatf("u%0d_write_sing", u), write_v[u], exp_write[u]);
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          wr = 5 + 49 * (k + 1);
          if (e == wr - 1) checkOutput($sformatf("u%0d_write_hold_k%0d", u, k), write_v[u], exp_write[u]);
          if (e == wr) begin
            exp_write[u] = q[k];
            checkOutput($sformatf("u%0d_write_k%0d", u, k), write_v[u], exp_write[u]);
          end
        end
      end
    end
    checkOutput($sformatf("u%0d_ram1_end", u), ram1_v[u], m[3]);
    if (hold) begin
      tick();
      checkOutput($sformatf("u%0d_ram1_idle", u), ram1_v[u], m[3]);
      start_v[u] = 1'b0;
      tick();
      checkOutput($sformatf("u%0d_restart_w0", u), ram1_v[u], m[0]);
      tick();
      checkOutput($sformatf("u%0d_restart_w1", u), ram1_v[u], m[1]);
      resetUnit(u);
    end
  endtask

  // Starts a run and asserts reset so that it is sampled at edge redge.
  task automatic abortRun(input int u, input int redge);
    logic [3:0][31:0] m, q;
    bit sing;
    logic [31:0] pre;
    m = getMatrix(u);
    refModel(m, q, sing);
    pre = exp_write[u];
    for (int k = 0; k < 4; k++)
      if (!sing && 5 + 49 * (k + 1) <= redge - 1) pre = q[k];
    start_v[u] = 1'b1;
    tick();
    start_v[u] = 1'b0;
    for (int e = 1; e < redge; e++) tick();
    checkOutput($sformatf("u%0d_write_before_abort", u), write_v[u], pre);
    rst_v[u] = 1'b1;
    tick();
    rst_v[u] = 1'b0;
    exp_write[u] = '0;
    checkOutput($sformatf("u%0d_ram1_abort", u), ram1_v[u], 32'h0);
    checkOutput($sformatf("u%0d_write_abort", u), write_v[u], 32'h0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput($sformatf("u%0d_write_after_abort", u), write_v[u], 32'h0);
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst_v[u]     = 1'b1;
      start_v[u]   = 1'b0;
      exp_write[u] = '0;
    end
    tick();
    tick();
    for (int u = 0; u < NU; u++) rst_v[u] = 1'b0;

    $display("[TB] idle check after reset");
    for (int cyc = 0; cyc < 500; cyc++) begin
      tick();
      if (cyc % 100 == 0)
        for (int u = 0; u < NU; u++) begin
          checkOutput($sformatf("u%0d_idle_ram1_c%0d", u, cyc), ram1_v[u], 32'h0);
          checkOutput($sformatf("u%0d_idle_write_c%0d", u, cyc), write_v[u], 32'h0);
        end
    end

    $display("[TB] two randomised runs per unit");
    for (int pass = 0; pass < 2; pass++)
      for (int u = 0; u < NU; u++) begin
        repeat ($urandom_range(0, 6)) tick();
        applyStimulus(u, int'($urandom_range(1, 3)), 1'b0);
      end

    $display("[TB] start held high through completion");
    applyStimulus(0, 1, 1'b1);
    applyStimulus(1, 1, 1'b1);
    applyStimulus(3, 1, 1'b1);

    $display("[TB] reset in the middle of a run");
    abortRun(0, 80);
    applyStimulus(0, 1, 1'b0);
    abortRun(3, int'($urandom_range(6, 200)));
    applyStimulus(3, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inverse_matrix.md
# inverse_matrix

Sequential 2x2 matrix inverter on signed Q16.16 fixed-point data. On a start pulse it reads the four matrix words from its internal input RAM and computes the determinant. It then produces the four inverse elements with one shared iterative divider and writes them to an internal result RAM. It is a standalone compute block. The two output ports expose the word being read (`ram1`) and the word being written (`write`) for observation.

## Interface
Parameters:
- `M00`, default 32'h0004_0000 (4.0): input RAM word 0, element a.
- `M01`, default 32'h0007_0000 (7.0): input RAM word 1, element b.
- `M10`, default 32'h0002_0000 (2.0): input RAM word 2, element c.
- `M11`, default 32'h0006_0000 (6.0): input RAM word 3, element d.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin inversion; sampled only in IDLE.
- `ram1`  out  32  registered input-RAM word currently read.
- `write`  out  32  registered result word most recently written.

## Operation
- The input RAM holds 4 words, loaded from the parameters at reset.
- The result RAM holds 4 words (inv00, inv01, inv10, inv11) and is cleared at reset.
- All values are signed two's complement Q16.16.
- State machine: IDLE -> READ -> DET -> (SING | DIV) ; DIV -> WR ; WR -> DIV (next element) | DONE ; SING -> DONE ; DONE -> IDLE.
- IDLE: when `start`=1, clear the element index and go to READ.
- READ: 4 cycles. Word k (0..3) is latched into the a/b/c/d registers and driven on `ram1`.
- DET: a*d and b*c are formed as 64-bit signed products. det = (a*d - b*c) >>> 16, arithmetic shift, truncated to 32 bits.
- If det == 0, go to SING. Otherwise go to DIV with element 0.
- Numerators per element: inv00 = d, inv01 = -b, inv10 = -c, inv11 = a.
- DIV: signed quotient (num <<< 16) / det.
  - 48-bit dividend, restoring shift-subtract on magnitudes, exactly 48 cycles.
  - Sign is applied afterwards; the quotient truncates toward zero.
- The quotient saturates to 32'h7FFF_FFFF or 32'h8000_0000 if it exceeds the 32-bit signed range.
- WR: 1 cycle. The quotient is stored in result RAM[k] and on `write`. k increments; after k=3 go to DONE.
- SING: result RAM words are unchanged; `write` = 32'h8000_0000.
- DONE: 1 cycle, then IDLE. If `start` is still high in IDLE, a new inversion begins.
- `start` is ignored outside IDLE.

## Timing
- Reset values: `ram1`=0, `write`=0, state IDLE, index 0, divider registers 0.
- Reset is accepted in any state; it aborts the operation and restores the reset values on the next edge.
- Let cycle 0 be the edge that samples `start`=1 in IDLE. Then:
  - `ram1` shows words 0..3 after edges 1..4.
  - DET occupies edge 5.
  - Element k's WR edge is 5 + 49*(k+1). `write` updates after edges 54, 103, 152, 201.
  - DONE is edge 202; IDLE at edge 203.
- Singular matrix: `write` = 32'h8000_0000 after edge 6. IDLE at edge 8.
- `ram1` and `write` hold their last values between updates.

## Configuration
- `INVERSE_MATRIX_ROUND_EN` defined: the divider rounds half away from zero. If 2*|remainder| >= |det|, the magnitude is incremented before the sign is applied. Saturation still applies.
- `INVERSE_MATRIX_ROUND_EN` undefined: truncation toward zero as above.

## Test plan
- Hold `rst`=1 for 2 cycles, `start`=0 for 500 cycles -> `ram1`=0 and `write`=0 throughout; no state change.
- Default matrix, `start` pulse, truncation build -> `write` sequence 32'h0000_9999, 32'hFFFF_4CCD, 32'hFFFF_CCCD, 32'h0000_6666 at edges 54/103/152/201. `ram1` shows 0x40000, 0x70000, 0x20000, 0x60000 at edges 1-4.
- Same stimulus with `INVERSE_MATRIX_ROUND_EN` -> 32'h0000_999A, 32'hFFFF_4CCD, 32'hFFFF_CCCD, 32'h0000_6666.
- M00=2.0, M01=4.0, M10=1.0, M11=2.0 (det 0) -> `write`=32'h8000_0000 at edge 6. Result RAM stays all zero; IDLE at edge 8.
- Identity (M00=M11=32'h0001_0000, others 0) -> results 32'h0001_0000, 0, 0, 32'h0001_0000.
- Assert `rst` at edge 80 mid-run -> `ram1`=`write`=0 next edge. A subsequent `start` reruns with the full 203-edge latency.
